// File: rtl/lampfpu_f2i_round_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lampfpu_f2i_round_if : handshake and data bundle for the f2i rounding stage
// Rev 1.0
// ---------------------------------------------------------------------------
interface lampfpu_f2i_round_if #(
  parameter int INT_DW = 32
);
  logic              valid_i;
  logic              ready_o;
  logic              s_i;
  logic [INT_DW+2:0] f_i;
  logic              isOverflow_i;
  logic              isSNaN_i;
  logic              isQNaN_i;
  logic [2:0]        rndMode_i;
  logic              valid_o;
  logic              ready_i;
  logic [INT_DW-1:0] result_o;
  logic [1:0]        flags_o;
  logic [1:0]        fflags_o;
  logic              clrFlags_i;

  modport slave (
    input  valid_i, s_i, f_i, isOverflow_i, isSNaN_i, isQNaN_i, rndMode_i,
           ready_i, clrFlags_i,
    output ready_o, valid_o, result_o, flags_o, fflags_o
  );

  modport master (
    output valid_i, s_i, f_i, isOverflow_i, isSNaN_i, isQNaN_i, rndMode_i,
           ready_i, clrFlags_i,
    input  ready_o, valid_o, result_o, flags_o, fflags_o
  );
endinterface
`default_nettype wire

// File: rtl/lampfpu_f2i_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lampfpu_f2i_round : 2-stage float-to-int rounding, saturation and flags
// Rev 1.0
// ---------------------------------------------------------------------------
module lampfpu_f2i_round #(
  parameter int INT_DW      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lampfpu_f2i_round_if.slave     bus
);

  generate
    if (PIPE_STAGES != 2) begin : g_stage_check
      $error("lampfpu_f2i_round supports PIPE_STAGES == 2 only");
    end
  endgenerate

  localparam logic [INT_DW:0]   C_HALF    = {2'b01, {(INT_DW-1){1'b0}}};
  localparam logic [INT_DW-1:0] C_POS_MAX = {1'b0, {(INT_DW-1){1'b1}}};
  localparam logic [INT_DW-1:0] C_NEG_MAX = {1'b1, {(INT_DW-1){1'b0}}};

  localparam logic [2:0] C_RNE = 3'b000;
  localparam logic [2:0] C_RTZ = 3'b001;
  localparam logic [2:0] C_RDN = 3'b010;
  localparam logic [2:0] C_RUP = 3'b011;
  localparam logic [2:0] C_RMM = 3'b100;

  // Stage 1 registers
  logic              s1_valid_q;
  logic              s1_sign_q;
  logic [INT_DW-1:0] s1_mag_q;
  logic              s1_inc_q;
  logic              s1_nan_q;
  logic              s1_ovf_q;
  logic              s1_inexact_q;

  // Stage 2 registers
  logic              s2_valid_q;
  logic [INT_DW-1:0] result_q;
  logic [1:0]        flags_q;
  logic [1:0]        fflags_q;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_g;
  logic              w_st;
  logic              w_lsb;
  logic              inc_d;
  logic [INT_DW:0]   w_rounded;
  logic              w_ovf;
  logic              w_nv;
  logic [INT_DW-1:0] result_d;
  logic [1:0]        flags_d;
  logic [1:0]        fflags_d;

  assign w_s2_adv = ~s2_valid_q | bus.ready_i;
  assign w_s1_adv = ~s1_valid_q | w_s2_adv;

  assign bus.ready_o  = w_s1_adv;
  assign bus.valid_o  = s2_valid_q;
  assign bus.result_o = result_q;
  assign bus.flags_o  = flags_q;
  assign bus.fflags_o = fflags_q;

  assign w_g   = bus.f_i[2];
  assign w_st  = bus.f_i[1] | bus.f_i[0];
  assign w_lsb = bus.f_i[3];

  always_comb begin
    inc_d = w_g & (w_st | w_lsb);
    case (bus.rndMode_i)
      C_RNE:   inc_d = w_g & (w_st | w_lsb);
      C_RTZ:   inc_d = 1'b0;
      C_RDN:   inc_d = bus.s_i & (w_g | w_st);
      C_RUP:   inc_d = ~bus.s_i & (w_g | w_st);
      C_RMM:   inc_d = w_g;
      default: inc_d = w_g & (w_st | w_lsb);
    endcase
  end

  // One extra bit keeps the carry out of an all-ones magnitude visible to the overflow test.
  always_comb begin
    w_rounded = {1'b0, s1_mag_q} + {{INT_DW{1'b0}}, s1_inc_q};
    w_ovf     = s1_ovf_q
              | (~s1_sign_q & (w_rounded >= C_HALF))
              | ( s1_sign_q & (w_rounded >  C_HALF));
    w_nv      = s1_nan_q | w_ovf;
    if (s1_nan_q) begin
      result_d = C_POS_MAX;
    end else if (w_ovf) begin
      result_d = s1_sign_q ? C_NEG_MAX : C_POS_MAX;
    end else if (s1_sign_q) begin
      result_d = {INT_DW{1'b0}} - w_rounded[INT_DW-1:0];
    end else begin
      result_d = w_rounded[INT_DW-1:0];
    end
    flags_d = {w_nv, s1_inexact_q & ~w_nv};
  end

  always_comb begin
    fflags_d = fflags_q;
    if (bus.clrFlags_i) begin
      fflags_d = 2'b00;
    end else if (s2_valid_q & bus.ready_i) begin
      fflags_d = fflags_q | flags_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_mag_q     <= '0;
      s1_inc_q     <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_inexact_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      flags_q      <= 2'b00;
      fflags_q     <= 2'b00;
    end else begin
      fflags_q <= fflags_d;
      if (w_s1_adv) begin
        s1_valid_q <= bus.valid_i;
        if (bus.valid_i) begin
          s1_sign_q    <= bus.s_i;
          s1_mag_q     <= bus.f_i[INT_DW+2:3];
          s1_inc_q     <= inc_d;
          s1_nan_q     <= bus.isSNaN_i | bus.isQNaN_i;
          s1_ovf_q     <= bus.isOverflow_i;
          s1_inexact_q <= w_g | w_st;
        end
      end
      if (w_s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q <= result_d;
          flags_q  <= flags_d;
        end
      end
    end
  end

endmodule
`default_nettype wire
